// File: rtl/emif_seq_pkg.sv
// Shared types and register offsets for the EMIF reset/calibration sequencer.
package emif_seq_pkg;

  localparam logic [15:0] DFH_START_OFFSET       = 16'h0000;
  localparam logic [15:0] EMIF_STATUS_OFFSET     = 16'h0008;
  localparam logic [15:0] EMIF_CAPABILITY_OFFSET = 16'h0010;
  localparam logic [15:0] EMIF_CONTROL_OFFSET    = 16'h0018;

  localparam logic [11:0] EMIF_DFH_FEAT_ID = 12'h9;

  typedef struct packed {
    logic [3:0]  feat_type;
    logic [18:0] rsvd;
    logic        eol;
    logic [23:0] next_offset;
    logic [3:0]  feat_rev;
    logic [11:0] feat_id;
  } t_dfh;

  typedef enum logic [2:0] {
    StIdle,
    StRstAssert,
    StWaitAck,
    StWaitCal,
    StDone
  } t_seq_state;

  typedef struct packed {
    logic [31:0] rsvd_hi;
    logic        busy;
    logic        seq_done;
    logic        seq_err;
    logic [3:0]  rsvd_lo;
    logic        ack_tmo;
    logic [7:0]  tmo;
    logic [7:0]  fail;
    logic [7:0]  succ;
  } t_emif_status;

endpackage

// File: rtl/emif_seq_timer.sv
// Loadable saturating 32-bit up-counter with a >= limit compare.
module emif_seq_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] limit,
  output logic        hit
);

  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count_q <= '0;
    end else if (count_q != '1) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign hit = (count_q >= limit);

endmodule

// File: rtl/emif_rst_cal_seq.sv
// Sequences mem_ss reset and calibration bring-up and exposes status through a small CSR slave.
module emif_rst_cal_seq
  import emif_seq_pkg::*;
#(
  parameter int unsigned       NUM_CH       = 4,
  parameter logic [NUM_CH-1:0] CH_MASK      = {NUM_CH{1'b1}},
  parameter int unsigned       RST_HOLD_CYC = 16,
  parameter int unsigned       ACK_TMO_CYC  = 1024,
  parameter int unsigned       CAL_TMO_CYC  = 65536,
  parameter logic [63:0]       DFH_VAL      = 64'h3_00000_06B000_1009
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_wr,
  input  logic              csr_rd,
  input  logic [15:0]       csr_addr,
  input  logic [63:0]       csr_wdata,
  output logic [63:0]       csr_rdata,
  output logic              csr_rd_valid,
  output logic              mem_ss_rst_req,
  input  logic              mem_ss_rst_ack,
  input  logic [NUM_CH-1:0] cal_success,
  input  logic [NUM_CH-1:0] cal_fail,
  output logic              seq_done,
  output logic              seq_err
);

  localparam t_dfh Dfh = t_dfh'(DFH_VAL);

  t_seq_state        state_q, state_d;
  logic [NUM_CH-1:0] succ_q, succ_d, fail_q, fail_d, tmo_q, tmo_d, new_res;
  logic              ack_tmo_q, ack_tmo_d, req_q;
  logic              ctrl_wr, restart, abort;
  logic              tmr_load, tmr_hit;
  logic [31:0]       tmr_limit;
  logic [63:0]       rdata_q, rdata_d;
  logic              rd_valid_q;
  t_emif_status      status;
  logic              unused_wdata;

  assign ctrl_wr      = csr_wr && (csr_addr == EMIF_CONTROL_OFFSET);
  assign restart      = ctrl_wr && csr_wdata[0];
  assign abort        = ctrl_wr && !csr_wdata[0] && csr_wdata[1];
  assign unused_wdata = ^csr_wdata[63:2];

  // A channel only resolves once; later level changes on it are ignored.
  assign new_res = (cal_success | cal_fail) & CH_MASK & ~(succ_q | fail_q);

  always_comb begin
    state_d   = state_q;
    succ_d    = succ_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    ack_tmo_d = ack_tmo_q;
    tmr_limit = '1;
    unique case (state_q)
      StIdle: ;
      StRstAssert: begin
        tmr_limit = 32'(RST_HOLD_CYC - 1);
        if (req_q && tmr_hit) state_d = StWaitAck;
      end
      StWaitAck: begin
        tmr_limit = 32'(ACK_TMO_CYC);
        if (mem_ss_rst_ack) begin
          state_d = StWaitCal;
        end else if (tmr_hit) begin
          ack_tmo_d = 1'b1;
          state_d   = StDone;
        end
      end
      StWaitCal: begin
        tmr_limit = 32'(CAL_TMO_CYC);
        succ_d = succ_q | (new_res & cal_success & ~cal_fail);
        fail_d = fail_q | (new_res & cal_fail);
        if ((succ_d | fail_d) == CH_MASK) begin
          state_d = StDone;
        end else if (tmr_hit) begin
          tmo_d   = CH_MASK & ~(succ_d | fail_d);
          state_d = StDone;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
    if (restart) begin
      state_d   = StRstAssert;
      succ_d    = '0;
      fail_d    = '0;
      tmo_d     = '0;
      ack_tmo_d = 1'b0;
    end else if (abort) begin
      state_d = StIdle;
    end
  end

  // Hold the count at 0 in the first cycle out of reset so req stays high a full hold period.
  assign tmr_load = (state_d != state_q) || restart || (state_q == StRstAssert && !req_q);

  emif_seq_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .limit (tmr_limit),
    .hit   (tmr_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRstAssert;
      succ_q    <= '0;
      fail_q    <= '0;
      tmo_q     <= '0;
      ack_tmo_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      succ_q    <= succ_d;
      fail_q    <= fail_d;
      tmo_q     <= tmo_d;
      ack_tmo_q <= ack_tmo_d;
      req_q     <= (state_d == StRstAssert);
    end
  end

  assign seq_done       = (state_q == StDone);
  assign seq_err        = seq_done && ((|fail_q) || (|tmo_q) || ack_tmo_q);
  assign mem_ss_rst_req = req_q;

  always_comb begin
    status          = '0;
    status.succ     = 8'(succ_q);
    status.fail     = 8'(fail_q);
    status.tmo      = 8'(tmo_q);
    status.ack_tmo  = ack_tmo_q;
    status.seq_err  = seq_err;
    status.seq_done = seq_done;
    status.busy     = state_q inside {StRstAssert, StWaitAck, StWaitCal};
  end

  always_comb begin
    rdata_d = '0;
    case (csr_addr)
      DFH_START_OFFSET:   rdata_d = Dfh;
      EMIF_STATUS_OFFSET: rdata_d = status;
      EMIF_CAPABILITY_OFFSET: begin
        rdata_d[7:0]  = 8'(CH_MASK);
        rdata_d[15:8] = 8'(NUM_CH);
      end
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= csr_rd;
      if (csr_rd) rdata_q <= rdata_d;
    end
  end

  assign csr_rdata    = rdata_q;
  assign csr_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_emif_rst_cal_seq.sv
// Randomized self-checking bench for emif_rst_cal_seq against a per-sequence outcome model.
module tb_emif_rst_cal_seq;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned RST_HOLD = 16;
  localparam int unsigned ACK_TMO  = 1024;
  localparam int unsigned CAL_TMO  = 65536;
  localparam logic [15:0] A_DFH    = 16'h0000;
  localparam logic [15:0] A_STATUS = 16'h0008;
  localparam logic [15:0] A_CAP    = 16'h0010;
  localparam logic [15:0] A_CTRL   = 16'h0018;

  logic              clk;
  logic              rst;
  logic              csr_wr;
  logic              csr_rd;
  logic [15:0]       csr_addr;
  logic [63:0]       csr_wdata;
  logic [63:0]       csr_rdata;
  logic              csr_rd_valid;
  logic              mem_ss_rst_req;
  logic              mem_ss_rst_ack;
  logic [NUM_CH-1:0] cal_success;
  logic [NUM_CH-1:0] cal_fail;
  logic              seq_done;
  logic              seq_err;

  emif_rst_cal_seq #(
    .NUM_CH       (NUM_CH),
    .CH_MASK      (4'hF),
    .RST_HOLD_CYC (RST_HOLD),
    .ACK_TMO_CYC  (ACK_TMO),
    .CAL_TMO_CYC  (CAL_TMO),
    .DFH_VAL      (64'h3_00000_06B000_1009)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .csr_wr         (csr_wr),
    .csr_rd         (csr_rd),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_rd_valid   (csr_rd_valid),
    .mem_ss_rst_req (mem_ss_rst_req),
    .mem_ss_rst_ack (mem_ss_rst_ack),
    .cal_success    (cal_success),
    .cal_fail       (cal_fail),
    .seq_done       (seq_done),
    .seq_err        (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every completed req pulse must last exactly the hold time.
  bit mon_en = 1'b1;
  int hi_len = 0;
  always @(negedge clk) begin
    if (mem_ss_rst_req === 1'b1) begin
      hi_len++;
    end else begin
      if (mon_en && hi_len != 0) check_val("req_hold_len", 64'(hi_len), 64'(RST_HOLD));
      hi_len = 0;
    end
  end

  // Per-channel outcome: 0 success, 1 fail, 2 both (fail wins), 3 never resolves.
  int oc [NUM_CH];
  int cdly [NUM_CH];
  int ack_dly;

  function automatic logic [63:0] model_status(input bit ack_to);
    logic [63:0] s;
    logic [7:0]  sc, fl, tm;
    s = '0; sc = '0; fl = '0; tm = '0;
    if (!ack_to) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (oc[ch] == 0) sc[ch] = 1'b1;
        else if (oc[ch] == 3) tm[ch] = 1'b1;
        else fl[ch] = 1'b1;
      end
    end
    s[7:0]   = sc;
    s[15:8]  = fl;
    s[23:16] = tm;
    s[24]    = ack_to;
    s[29]    = ack_to || (fl != 0) || (tm != 0);
    s[30]    = 1'b1;
    return s;
  endfunction

  task automatic csr_read(input logic [15:0] a, output logic [63:0] d);
    csr_rd   = 1'b1;
    csr_addr = a;
    @(negedge clk);
    csr_rd = 1'b0;
    check_val("rd_valid_rise", 64'(csr_rd_valid), 64'd1);
    d = csr_rdata;
    @(negedge clk);
    check_val("rd_valid_fall", 64'(csr_rd_valid), 64'd0);
  endtask

  task automatic csr_write(input logic [15:0] a, input logic [63:0] d);
    csr_wr    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    @(negedge clk);
    csr_wr = 1'b0;
  endtask

  task automatic clear_inputs();
    mem_ss_rst_ack = 1'b0;
    cal_success    = '0;
    cal_fail       = '0;
  endtask

  task automatic restart_seq();
    logic [63:0] d;
    clear_inputs();
    csr_write(A_CTRL, 64'd1);
    csr_read(A_STATUS, d);
    check_val("restart_status", d, 64'h8000_0000);
  endtask

  task automatic wait_req_fall();
    int t;
    t = 0;
    while (mem_ss_rst_req !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check_val("req_rise", 64'(mem_ss_rst_req), 64'd1);
    t = 0;
    while (mem_ss_rst_req === 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check_val("req_fall", 64'(mem_ss_rst_req), 64'd0);
  endtask

  // Plays the ack/calibration schedule, counted from the cycle req fell, until seq_done.
  task automatic drive_seq(input int bound, output int t_done);
    logic [NUM_CH-1:0] sv, fv;
    int t;
    t = 0;
    while (seq_done !== 1'b1 && t < bound) begin
      sv = '0;
      fv = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (oc[ch] != 3 && t >= ack_dly + cdly[ch]) begin
          if (oc[ch] != 1) sv[ch] = 1'b1;
          if (oc[ch] != 0) fv[ch] = 1'b1;
        end
      end
      mem_ss_rst_ack = (t >= ack_dly);
      cal_success    = sv;
      cal_fail       = fv;
      @(negedge clk);
      t++;
    end
    t_done = t;
    check_val("seq_done", 64'(seq_done), 64'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, exp;
    int t;
    rst = 1'b1; csr_wr = 1'b0; csr_rd = 1'b0; csr_addr = '0; csr_wdata = '0;
    clear_inputs();
    repeat (3) @(negedge clk);
    check_val("rst_req", 64'(mem_ss_rst_req), 64'd0);
    check_val("rst_done", 64'(seq_done), 64'd0);
    check_val("rst_err", 64'(seq_err), 64'd0);
    check_val("rst_rd_valid", 64'(csr_rd_valid), 64'd0);
    check_val("rst_rdata", csr_rdata, 64'd0);
    rst = 1'b0;

    // Auto-start out of reset: ack 20 cycles after req falls, calibration 100 cycles later.
    wait_req_fall();
    ack_dly = 20;
    for (int ch = 0; ch < NUM_CH; ch++) begin oc[ch] = 0; cdly[ch] = 100; end
    drive_seq(500, t);
    csr_read(A_STATUS, d);
    check_val("boot_status", d, 64'h4000_000F);
    check_val("boot_err", 64'(seq_err), 64'd0);

    csr_read(A_DFH, d);
    check_val("dfh", d, 64'h3_00000_06B000_1009);
    csr_read(A_CAP, d);
    check_val("capability", d, 64'h0000_0000_0000_040F);
    csr_read(A_CTRL, d);
    check_val("control_rd", d, 64'd0);

    for (int k = 0; k < 6; k++) begin
      restart_seq();
      wait_req_fall();
      ack_dly = int'($urandom_range(1, 40));
      for (int ch = 0; ch < NUM_CH; ch++) begin
        oc[ch]   = int'($urandom_range(0, 2));
        cdly[ch] = int'($urandom_range(1, 60));
      end
      drive_seq(400, t);
      exp = model_status(1'b0);
      csr_read(A_STATUS, d);
      check_val("rand_status", d, exp);
      check_val("rand_err_pin", 64'(seq_err), 64'(exp[29]));
    end

    // Ack never arrives.
    restart_seq();
    wait_req_fall();
    ack_dly = 1 << 30;
    drive_seq(ACK_TMO + 50, t);
    check_val("ack_tmo_latency", 64'(t >= ACK_TMO && t <= ACK_TMO + 2), 64'd1);
    csr_read(A_STATUS, d);
    check_val("ack_tmo_status", d, model_status(1'b1));
    check_val("ack_tmo_err", 64'(seq_err), 64'd1);
    check_val("ack_tmo_req", 64'(mem_ss_rst_req), 64'd0);

    // ch2 sees success and fail together, ch3 never resolves.
    restart_seq();
    wait_req_fall();
    ack_dly = 5;
    oc[0] = 0; oc[1] = 0; oc[2] = 2; oc[3] = 3;
    for (int ch = 0; ch < NUM_CH; ch++) cdly[ch] = 3;
    drive_seq(CAL_TMO + 200, t);
    csr_read(A_STATUS, d);
    check_val("cal_tmo_status", d, 64'h6008_0403);
    check_val("cal_tmo_model", d, model_status(1'b0));
    check_val("cal_tmo_err", 64'(seq_err), 64'd1);

    // Restart mid calibration must not leave stale captures.
    restart_seq();
    wait_req_fall();
    mem_ss_rst_ack = 1'b1;
    repeat (3) @(negedge clk);
    cal_fail    = 4'b0001;
    cal_success = 4'b0010;
    repeat (3) @(negedge clk);
    restart_seq();
    wait_req_fall();
    ack_dly = 4;
    for (int ch = 0; ch < NUM_CH; ch++) begin oc[ch] = 0; cdly[ch] = 2; end
    drive_seq(400, t);
    csr_read(A_STATUS, d);
    check_val("mid_restart_status", d, 64'h4000_000F);

    // Abort lands in idle; restart together with abort wins.
    mon_en = 1'b0;
    clear_inputs();
    csr_write(A_CTRL, 64'd1);
    csr_write(A_CTRL, 64'd2);
    @(negedge clk);
    check_val("abort_req", 64'(mem_ss_rst_req), 64'd0);
    csr_read(A_STATUS, d);
    check_val("abort_status", d, 64'd0);
    mon_en = 1'b1;
    csr_write(A_CTRL, 64'd3);
    csr_read(A_STATUS, d);
    check_val("restart_abort_status", d, 64'h8000_0000);

    // Synchronous reset pulse during calibration.
    wait_req_fall();
    mem_ss_rst_ack = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    check_val("midrst_req", 64'(mem_ss_rst_req), 64'd0);
    check_val("midrst_done", 64'(seq_done), 64'd0);
    check_val("midrst_err", 64'(seq_err), 64'd0);
    check_val("midrst_rd_valid", 64'(csr_rd_valid), 64'd0);
    check_val("midrst_rdata", csr_rdata, 64'd0);
    wait_req_fall();
    csr_read(16'h0020, d);
    check_val("unmapped_rd", d, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/emif_rst_cal_seq.md
Name: emif_rst_cal_seq

Overview:
- Sequences reset and calibration bring-up of the memory subsystem (mem_ss), then reports per-channel calibration status.
- Exposes the EMIF feature through a small CSR slave: DFH at 0x0, STATUS at 0x8, CAPABILITY at 0x10, CONTROL at 0x18.
- Sits between the host CSR fabric and the mem_ss reset/calibration sideband.
- Software can re-launch the sequence at any time through CONTROL.

Parameters:
- NUM_CH, 4, number of EMIF channels (1..8)
- CH_MASK, 4'hF, channels populated; reported in CAPABILITY
- RST_HOLD_CYC, 16, cycles mem_ss_rst_req is held high
- ACK_TMO_CYC, 1024, max cycles waiting for mem_ss_rst_ack
- CAL_TMO_CYC, 65536, max cycles waiting for calibration result
- DFH_VAL, 64'h3_00000_06B000_1009, DFH read value (feat_type 3, feat_id 0x9, next offset 0x06B000, eol 0)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- csr_wr  in  1  write strobe, single cycle
- csr_rd  in  1  read strobe, single cycle
- csr_addr  in  16  byte address, 8-byte aligned
- csr_wdata  in  64  write data
- csr_rdata  out  64  read data
- csr_rd_valid  out  1  read data valid
- mem_ss_rst_req  out  1  reset request to mem_ss
- mem_ss_rst_ack  in  1  mem_ss reset-complete acknowledge, level
- cal_success  in  NUM_CH  per-channel calibration pass, level
- cal_fail  in  NUM_CH  per-channel calibration fail, level
- seq_done  out  1  sequence finished; level, high in DONE
- seq_err  out  1  any fail or timeout in the last sequence; level

Behaviour:
- Reset: every output is 0, the FSM enters RST_ASSERT, all counters are 0, and the STATUS captures are 0. The sequence therefore starts automatically out of reset.
- FSM states: IDLE, RST_ASSERT, WAIT_ACK, WAIT_CAL, DONE.
- RST_ASSERT: mem_ss_rst_req=1 for exactly RST_HOLD_CYC cycles, then go to WAIT_ACK with mem_ss_rst_req=0.
- WAIT_ACK:
  - mem_ss_rst_ack=1 goes to WAIT_CAL.
  - If the counter reaches ACK_TMO_CYC first, set ack_tmo and go to DONE.
- WAIT_CAL:
  - A channel i in CH_MASK is resolved when cal_success[i] or cal_fail[i] is high.
  - Resolved bits are captured sticky into succ_q / fail_q. If success and fail are both high for a channel, fail wins.
  - When all masked channels are resolved, go to DONE.
  - If CAL_TMO_CYC is reached first, set tmo_q[i] for every unresolved masked channel and go to DONE.
  - Channels outside CH_MASK are ignored and read 0.
- DONE: seq_done=1 and seq_err = |fail_q or |tmo_q or ack_tmo. The FSM stays in DONE until restarted.
- IDLE: entered only when software writes CONTROL with bit0=0 and bit1=1 (abort). mem_ss_rst_req=0 in IDLE.
- Restart:
  - A write to CONTROL (0x18) with bit0=1 from any state clears succ_q/fail_q/tmo_q/ack_tmo, seq_done and seq_err.
  - It also reloads the counter and goes to RST_ASSERT on the next cycle. The bit is self-clearing and reads 0.
  - A restart during RST_ASSERT restarts the hold count from 0.
  - If restart and abort are both set, restart wins.
- Counters: 32-bit up-counter, cleared on every state entry; the compare uses >= so it saturates safely.
- CSR read: csr_rd_valid is asserted exactly 1 cycle after csr_rd, with csr_rdata registered in the same cycle. Register map:
  - 0x0: DFH_VAL
  - 0x8 STATUS: [7:0] succ_q, [15:8] fail_q, [23:16] tmo_q, [24] ack_tmo, [29] seq_err, [30] seq_done, [31] busy (state RST_ASSERT/WAIT_ACK/WAIT_CAL), [63:32] 0. Channel fields are zero-extended beyond NUM_CH.
  - 0x10 CAPABILITY: [7:0] CH_MASK, [15:8] NUM_CH, rest 0.
  - 0x18 CONTROL: reads 0.
  - Unmapped addresses read 0.
- CSR write: writes to addresses other than 0x18 are ignored. csr_rd and csr_wr in the same cycle are both serviced, and a read of STATUS returns the pre-write value.
- Reads while busy are allowed and return live status.
- rst asserted mid-sequence returns to the reset values and auto-starts a new sequence.

Decomposition:
- Package emif_seq_pkg holds:
  - t_dfh, the packed DFH struct;
  - the offsets DFH_START_OFFSET, EMIF_STATUS_OFFSET, EMIF_CAPABILITY_OFFSET and EMIF_CONTROL_OFFSET=0x18;
  - EMIF_DFH_FEAT_ID=12'h9;
  - t_seq_state, the enum of FSM states;
  - t_emif_status, the packed STATUS struct.
- One sub-module, emif_seq_timer: a loadable 32-bit counter with a >=limit compare. It is instanced once and reloaded on every state change.

Test Plan:
- Out of reset, ack at cycle 20 after req falls, then cal_success=4'hF 100 cycles later -> req high exactly 16 cycles; STATUS=0x4000_000F; seq_done=1, seq_err=0.
- Read 0x0 and 0x10 -> 0x3_00000_06B000_1009 and 0x0000_0000_0000_040F, each with csr_rd_valid exactly 1 cycle after csr_rd.
- mem_ss_rst_ack held 0 -> after 16+1024 cycles, DONE; STATUS bit24=1, seq_err=1, req=0.
- cal_success=4'b0111 and cal_fail=4'b0100, ch3 never resolves -> after 65536 cycles: succ=0x03, fail=0x04, tmo=0x08, seq_err=1.
- In DONE, write 0x18=1 -> next cycle busy=1, STATUS cleared except busy, req re-asserted for 16 cycles. Repeat the write mid-WAIT_CAL: the sequence restarts and no stale bits remain.
- Assert rst for 1 cycle during WAIT_CAL -> all outputs 0 the following cycle, then auto-restart with req high 16 cycles; an unmapped read of 0x20 returns 0.
